mdio_responder: RTL and testbench

PHY-side end of the team's MDIO management link: samples the frame the MDIO controller serializes on MDIO_OUT/MDC, decodes IEEE 802.3 Clause 22 write and read frames, and drives a simple register-file port. On reads it returns 16 data bits to the controller on MDIO_IN, and the controller captures them as RD_DATA. It sits between the MDIO controller and the PHY register bank. Controller and responder share clk, and MDC is sampled as data.

---
 rtl/mdio_responder.sv | 203 ++++++++++++++++++++
 tb/tb_mdio_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_responder.sv
// mdio_responder: PHY-side decoder for IEEE 802.3 Clause 22 MDIO frames.
// MDC is sampled as data on clk; every MDC edge is acted on the clk after it
// is seen, so all outputs are registered and strobes are one clk wide.
//
// Register-bank handshake: RD_STB is a one-clk request qualified by ADDR;
// the bank answers with RD_DATA valid on the following clk, and RD_DATA is
// captured exactly once, one clk after RD_STB. WR_STB is a one-clk command
// qualified by ADDR and WR_DATA, which are stable while it is high and hold
// afterwards. There is no back-pressure in either direction.
module mdio_responder #(
    parameter logic [4:0] PHY_ADDR = 5'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MDC,
    input  logic        MDIO_OE,
    input  logic        MDIO_OUT,
    input  logic [15:0] RD_DATA,
    output logic        MDIO_IN,
    output logic [4:0]  ADDR,
    output logic [15:0] WR_DATA,
    output logic        WR_STB,
    output logic        RD_STB,
    output logic        MDIO_DONE,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_TA     = 3'd2,
        S_WDATA  = 3'd3,
        S_RDATA  = 3'd4,
        S_RDONE  = 3'd5,
        S_SKIP   = 3'd6
    } state_t;

    state_t      state, state_n;
    logic        mdc_q;
    logic        rise, fall;
    logic [4:0]  bit_cnt, bit_cnt_n;   // index of the next frame bit to arrive
    logic [15:0] sr, sr_n, sr_shift;
    logic        op_rd, op_rd_n;
    logic        rd_cap;
    logic [4:0]  addr_n;
    logic [15:0] wr_data_n;
    logic        wr_stb_n, rd_stb_n, done_n, mdio_in_n;

    assign rise      = MDC & ~mdc_q;
    assign fall      = ~MDC & mdc_q;
    assign sr_shift  = {sr[14:0], MDIO_OUT};
    assign dbg_state = state;

    // State, datapath and output registers; synchronous active-low reset wins over any MDC edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            mdc_q     <= 1'b0;
            bit_cnt   <= 5'd0;
            sr        <= 16'd0;
            op_rd     <= 1'b0;
            rd_cap    <= 1'b0;
            MDIO_IN   <= 1'b0;
            ADDR      <= 5'd0;
            WR_DATA   <= 16'd0;
            WR_STB    <= 1'b0;
            RD_STB    <= 1'b0;
            MDIO_DONE <= 1'b0;
        end else begin
            state     <= state_n;
            mdc_q     <= MDC;
            bit_cnt   <= bit_cnt_n;
            sr        <= sr_n;
            op_rd     <= op_rd_n;
            rd_cap    <= RD_STB;
            MDIO_IN   <= mdio_in_n;
            ADDR      <= addr_n;
            WR_DATA   <= wr_data_n;
            WR_STB    <= wr_stb_n;
            RD_STB    <= rd_stb_n;
            MDIO_DONE <= done_n;
        end
    end

    // Frame decode: next state, bit counter, shift register and strobes.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        sr_n      = sr;
        op_rd_n   = op_rd;
        addr_n    = ADDR;
        wr_data_n = WR_DATA;
        wr_stb_n  = 1'b0;
        rd_stb_n  = 1'b0;
        done_n    = 1'b0;
        mdio_in_n = MDIO_IN;

        // Read data arrives one clk after RD_STB, always while still in TA.
        if (rd_cap) begin
            sr_n = RD_DATA;
        end

        case (state)
            S_IDLE: begin
                bit_cnt_n = 5'd0;
                mdio_in_n = 1'b0;
                if (rise && MDIO_OE) begin
                    sr_n      = sr_shift;
                    bit_cnt_n = 5'd1;
                    state_n   = S_HEADER;
                end
            end
            S_HEADER: begin
                if (rise) begin
                    if (!MDIO_OE) begin
                        bit_cnt_n = 5'd0;
                        state_n   = S_IDLE;
                    end else begin
                        sr_n      = sr_shift;
                        bit_cnt_n = bit_cnt + 5'd1;
                        if (bit_cnt == 5'd1) begin
                            if (sr_shift[1:0] != 2'b01) state_n = S_SKIP;
                        end else if (bit_cnt == 5'd3) begin
                            if (sr_shift[1:0] == 2'b10)      op_rd_n = 1'b1;
                            else if (sr_shift[1:0] == 2'b01) op_rd_n = 1'b0;
                            else                             state_n = S_SKIP;
                        end else if (bit_cnt == 5'd13) begin
                            // sr_shift[9:5] is PHYAD, sr_shift[4:0] is REGAD
                            if (sr_shift[9:5] != PHY_ADDR) begin
                                state_n = S_SKIP;
                            end else begin
                                addr_n   = sr_shift[4:0];
                                rd_stb_n = op_rd;
                                state_n  = S_TA;
                            end
                        end
                    end
                end
            end
            S_TA: begin
                if (fall) begin
                    mdio_in_n = 1'b0;
                end
                if (rise) begin
                    bit_cnt_n = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd15) begin
                        state_n = op_rd ? S_RDATA : S_WDATA;
                    end
                end
            end
            S_WDATA: begin
                if (rise) begin
                    if (!MDIO_OE) begin
                        bit_cnt_n = 5'd0;
                        state_n   = S_IDLE;
                    end else begin
                        sr_n      = sr_shift;
                        bit_cnt_n = bit_cnt + 5'd1;
                        if (bit_cnt == 5'd31) begin
                            wr_data_n = sr_shift;
                            wr_stb_n  = 1'b1;
                            done_n    = 1'b1;
                            state_n   = S_IDLE;
                        end
                    end
                end
            end
            S_RDATA: begin
                // Each fall presents the next data bit, MSB first, ahead of the controller's rise.
                if (fall) begin
                    mdio_in_n = sr[15];
                    sr_n      = {sr[14:0], 1'b0};
                end
                if (rise) begin
                    bit_cnt_n = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd31) begin
                        done_n  = 1'b1;
                        state_n = S_RDONE;
                    end
                end
            end
            S_RDONE: begin
                // Hold the last data bit until the fall after rise 31, then release to 0.
                if (fall) begin
                    mdio_in_n = 1'b0;
                    state_n   = S_IDLE;
                end
            end
            S_SKIP: begin
                mdio_in_n = 1'b0;
                if (rise) begin
                    bit_cnt_n = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd31) state_n = S_IDLE;
                end
            end
            default: begin
                bit_cnt_n = 5'd0;
                state_n   = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder: directed frames through the responder. A frame-level
// model derives, from each frame's fields, which strobes must appear at which
// MDC rise and what MDIO_IN must carry; a single compare process checks the
// DUT against it every clk.
module tb_mdio_responder;

    localparam logic [4:0] PHY = 5'd0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MDC = 1'b0;
    logic        MDIO_OE = 1'b0;
    logic        MDIO_OUT = 1'b0;
    logic [15:0] RD_DATA = 16'd0;
    logic        MDIO_IN;
    logic [4:0]  ADDR;
    logic [15:0] WR_DATA;
    logic        WR_STB;
    logic        RD_STB;
    logic        MDIO_DONE;
    logic [2:0]  dbg_state;

    mdio_responder #(.PHY_ADDR(PHY)) dut (
        .clk       (clk),
        .rst       (rst),
        .MDC       (MDC),
        .MDIO_OE   (MDIO_OE),
        .MDIO_OUT  (MDIO_OUT),
        .RD_DATA   (RD_DATA),
        .MDIO_IN   (MDIO_IN),
        .ADDR      (ADDR),
        .WR_DATA   (WR_DATA),
        .WR_STB    (WR_STB),
        .RD_STB    (RD_STB),
        .MDIO_DONE (MDIO_DONE),
        .dbg_state (dbg_state)
    );

    // Clock and edge bookkeeping
    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_seen = 1'b0;   // rst value sampled at the most recent posedge
    always @(posedge clk) begin
        cyc      = cyc + 1;
        rst_seen = rst;
    end

    // Register bank: answers a read request with data on the next clk only.
    logic [15:0] bank_val = 16'd0;
    always @(posedge clk) begin
        RD_DATA <= RD_STB ? bank_val : 16'hDEAD;
    end

    // Checking counters and helper
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Frame-level model state, recorded by the driver at each MDC rise
    int          r_cyc = -1;      // posedge at which the DUT sees the rise
    int          r_bit = 0;
    logic        r_hdr_ok = 1'b0;
    logic        r_wr_ok = 1'b0;
    logic        r_rd_ok = 1'b0;
    logic [4:0]  r_reg = 5'd0;
    logic [15:0] r_wdata = 16'd0;
    logic [15:0] r_rdval = 16'd0;
    logic        quiet = 1'b1;    // MDIO_IN must be 0 on every clk
    logic [4:0]  exp_addr = 5'd0;
    logic [15:0] exp_wr_data = 16'd0;
    logic [15:0] rx_word = 16'd0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          done_cnt = 0;

    // Compare process: DUT outputs against the model on every clk
    always @(negedge clk) begin
        logic at_rise;
        logic e_wr, e_rd, e_done, e_bit;
        at_rise = (cyc == r_cyc);
        if (!rst_seen) begin
            exp_addr    = 5'd0;
            exp_wr_data = 16'd0;
            check("reset_outputs", {MDIO_IN, ADDR, WR_DATA, WR_STB, RD_STB, MDIO_DONE}, 32'd0);
        end else begin
            e_rd   = at_rise && (r_bit == 13) && r_rd_ok;
            e_wr   = at_rise && (r_bit == 31) && r_wr_ok;
            e_done = at_rise && (r_bit == 31) && (r_wr_ok || r_rd_ok);
            if (at_rise && (r_bit == 13) && r_hdr_ok) exp_addr = r_reg;
            if (e_wr) exp_wr_data = r_wdata;
            check("wr_stb", WR_STB, e_wr);
            check("rd_stb", RD_STB, e_rd);
            check("mdio_done", MDIO_DONE, e_done);
            check("addr", ADDR, exp_addr);
            check("wr_data", WR_DATA, exp_wr_data);
            if (quiet) check("mdio_in_quiet", MDIO_IN, 0);
            if (at_rise && r_rd_ok) begin
                e_bit = 1'b0;
                if (r_bit >= 16) e_bit = r_rdval[31 - r_bit];
                check("mdio_in_bit", MDIO_IN, e_bit);
                if (r_bit >= 16) rx_word = {rx_word[14:0], MDIO_IN};
            end
            if (WR_STB) wr_cnt++;
            if (RD_STB) rd_cnt++;
            if (MDIO_DONE) done_cnt++;
        end
    end

    function automatic logic [31:0] mk(input logic [1:0] st, input logic [1:0] op,
                                       input logic [4:0] phy, input logic [4:0] rga,
                                       input logic [15:0] d);
        return {st, op, phy, rga, 2'b10, d};
    endfunction

    // Driver: serializes a frame; OE is low from bit oe_drop on; stops before stop_bit.
    task automatic send_frame(input logic [31:0] w, input int oe_drop, input int stop_bit,
                              input int h, input logic [15:0] rdval);
        logic hdr_ok, wr_ok, rd_ok;
        hdr_ok = (w[31:30] == 2'b01) && (w[29:28] == 2'b01 || w[29:28] == 2'b10) &&
                 (w[27:23] == PHY) && (oe_drop > 13);
        wr_ok  = hdr_ok && (w[29:28] == 2'b01) && (oe_drop > 31);
        rd_ok  = hdr_ok && (w[29:28] == 2'b10);
        bank_val = rdval;
        if (rd_ok) quiet = 1'b0;
        for (int k = 0; k < stop_bit; k++) begin
            MDC      = 1'b0;
            MDIO_OUT = w[31 - k];
            MDIO_OE  = (k < oe_drop);
            repeat (h) begin @(posedge clk); #1; end
            r_hdr_ok = hdr_ok;
            r_wr_ok  = wr_ok;
            r_rd_ok  = rd_ok;
            r_reg    = w[22:18];
            r_wdata  = w[15:0];
            r_rdval  = rdval;
            r_bit    = k;
            r_cyc    = cyc + 1;
            MDC      = 1'b1;
            repeat (h) begin @(posedge clk); #1; end
        end
    endtask

    task automatic idle(input int n);
        MDC      = 1'b0;
        MDIO_OE  = 1'b0;
        MDIO_OUT = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        quiet = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset(input int n);
        MDC      = 1'b0;
        MDIO_OE  = 1'b0;
        MDIO_OUT = 1'b0;
        rst      = 1'b0;
        r_cyc    = -1;
        repeat (n) begin @(posedge clk); #1; end
        rst = 1'b1;
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Directed tests
    initial begin
        int w0, r0, d0;
        repeat (3) begin @(posedge clk); #1; end
        check("reset_addr_lit", ADDR, 5'h00);
        check("reset_wr_data_lit", WR_DATA, 16'h0000);
        rst = 1'b1;
        idle(2);

        // Write BEEF to REGAD 3, MDC = clk/2
        w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt;
        send_frame(mk(2'b01, 2'b01, 5'h00, 5'h03, 16'hBEEF), 32, 32, 1, 16'h0000);
        idle(4);
        check("t1_addr_lit", ADDR, 5'h03);
        check("t1_wr_data_lit", WR_DATA, 16'hBEEF);
        check("t1_wr_count", wr_cnt - w0, 1);
        check("t1_rd_count", rd_cnt - r0, 0);
        check("t1_done_count", done_cnt - d0, 1);

        // Read REGAD 5 returning 8FF1; controller releases the line from TA
        w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt; rx_word = 16'd0;
        send_frame(mk(2'b01, 2'b10, 5'h00, 5'h05, 16'h0000), 14, 32, 1, 16'h8FF1);
        idle(4);
        check("t2_rx_word_lit", rx_word, 16'h8FF1);
        check("t2_addr_lit", ADDR, 5'h05);
        check("t2_wr_data_held", WR_DATA, 16'hBEEF);
        check("t2_rd_count", rd_cnt - r0, 1);
        check("t2_wr_count", wr_cnt - w0, 0);
        check("t2_done_count", done_cnt - d0, 1);

        // PHYAD mismatch
        w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt;
        send_frame(mk(2'b01, 2'b01, 5'h07, 5'h09, 16'h1234), 32, 32, 1, 16'h0000);
        idle(4);
        check("t3_wr_data_held", WR_DATA, 16'hBEEF);
        check("t3_addr_held", ADDR, 5'h05);
        check("t3_strobes", (wr_cnt - w0) + (rd_cnt - r0) + (done_cnt - d0), 0);

        // Bad ST directly followed by a valid write
        w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt;
        send_frame(mk(2'b00, 2'b01, 5'h00, 5'h1F, 16'hFFFF), 32, 32, 1, 16'h0000);
        send_frame(mk(2'b01, 2'b01, 5'h00, 5'h01, 16'hA5A5), 32, 32, 1, 16'h0000);
        idle(4);
        check("t4_wr_data_lit", WR_DATA, 16'hA5A5);
        check("t4_addr_lit", ADDR, 5'h01);
        check("t4_wr_count", wr_cnt - w0, 1);
        check("t4_done_count", done_cnt - d0, 1);

        // Reset at bit 20 of a write, then a read of REGAD 2
        w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt; rx_word = 16'd0;
        send_frame(mk(2'b01, 2'b01, 5'h00, 5'h0A, 16'h7777), 32, 20, 1, 16'h0000);
        do_reset(2);
        idle(2);
        send_frame(mk(2'b01, 2'b10, 5'h00, 5'h02, 16'h0000), 14, 32, 1, 16'h00FF);
        idle(4);
        check("t5_rx_word_lit", rx_word, 16'h00FF);
        check("t5_wr_data_cleared", WR_DATA, 16'h0000);
        check("t5_wr_count", wr_cnt - w0, 0);
        check("t5_rd_count", rd_cnt - r0, 1);
        check("t5_done_count", done_cnt - d0, 1);

        // OE dropped at bit 8 of a write, then a read at MDC = clk/4
        w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt; rx_word = 16'd0;
        send_frame(mk(2'b01, 2'b01, 5'h00, 5'h04, 16'hC3C3), 8, 32, 1, 16'h0000);
        idle(4);
        check("t6_abort_strobes", (wr_cnt - w0) + (rd_cnt - r0) + (done_cnt - d0), 0);
        check("t6_addr_held", ADDR, 5'h02);
        send_frame(mk(2'b01, 2'b10, 5'h00, 5'h06, 16'h0000), 14, 32, 2, 16'h6A5C);
        idle(4);
        check("t6_rx_word_lit", rx_word, 16'h6A5C);
        check("t6_addr_lit", ADDR, 5'h06);

        // Bad OP, then a write at MDC = clk/4
        w0 = wr_cnt; d0 = done_cnt;
        send_frame(mk(2'b01, 2'b11, 5'h00, 5'h0C, 16'h5555), 32, 32, 1, 16'h0000);
        send_frame(mk(2'b01, 2'b01, 5'h00, 5'h1F, 16'h0001), 32, 32, 2, 16'h0000);
        idle(4);
        check("t7_wr_data_lit", WR_DATA, 16'h0001);
        check("t7_addr_lit", ADDR, 5'h1F);
        check("t7_wr_count", wr_cnt - w0, 1);
        check("t7_done_count", done_cnt - d0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
